// File: rtl/xif_result_arbiter_pkg.sv
// ============================================================================
//  Module      : xif_result_arbiter_pkg
//  Description : Shared types and constants for the X-interface result
//                arbiter: the x_result_t payload layout, default channel
//                count and widths, and width helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xif_result_arbiter_pkg;

    localparam int N_COPROC_DEF = 3;
    localparam int ID_W_DEF     = 4;
    localparam int DATA_W_DEF   = 32;

    // id + data + rd[4:0] + we + exc + exccode[5:0]
    localparam int RES_W = ID_W_DEF + DATA_W_DEF + 5 + 1 + 1 + 6;

    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [DATA_W_DEF-1:0] data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    // Payload width for an arbitrary id/data width combination.
    function automatic int res_width(input int id_w, input int data_w);
        return id_w + data_w + 13;
    endfunction

    // Source-index width; a single channel still needs one bit of storage.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xif_result_arbiter_if.sv
// ============================================================================
//  Module      : xif_result_arbiter_if
//  Description : Bundles the coprocessor-side result channels and the core
//                result port of the result arbiter.
//                slave  : arbiter view (drives res_ready_o and core_*_o)
//                master : environment view (drives res_*_i and core_ready_i)
//  Signals     : res_valid_i[N], res_ready_o[N], res_i[N*RES_W],
//                core_valid_o, core_ready_i, core_res_o[RES_W],
//                core_src_o[SRC_W]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xif_result_arbiter_if
    import xif_result_arbiter_pkg::*;
#(
    parameter int N_COPROC = N_COPROC_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) ();

    localparam int RES_WIDTH = res_width(ID_W, DATA_W);
    localparam int SRC_WIDTH = src_width(N_COPROC);

    logic [N_COPROC-1:0]           res_valid_i;
    logic [N_COPROC-1:0]           res_ready_o;
    logic [N_COPROC*RES_WIDTH-1:0] res_i;
    logic                          core_valid_o;
    logic                          core_ready_i;
    logic [RES_WIDTH-1:0]          core_res_o;
    logic [SRC_WIDTH-1:0]          core_src_o;

    modport slave (
        input  res_valid_i, res_i, core_ready_i,
        output res_ready_o, core_valid_o, core_res_o, core_src_o
    );

    modport master (
        output res_valid_i, res_i, core_ready_i,
        input  res_ready_o, core_valid_o, core_res_o, core_src_o
    );

endinterface

`default_nettype wire

// File: rtl/xif_result_skid.sv
// ============================================================================
//  Module      : xif_result_skid
//  Description : Two-entry valid/ready skid buffer. Outputs come straight
//                from flops, and in_ready_o depends only on occupancy, so
//                there is no combinational path from out_ready_i to
//                in_ready_o. Sustains one transfer per cycle.
//  Ports       : clk_i, rst_ni (sync, active low)
//                in_valid_i / in_ready_o / in_data_i[W]
//                out_valid_o / out_ready_i / out_data_o[W]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xif_result_skid #(
    parameter int W = 8
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    input  wire logic         in_valid_i,
    output logic              in_ready_o,
    input  wire logic [W-1:0] in_data_i,
    output logic              out_valid_o,
    input  wire logic         out_ready_i,
    output logic [W-1:0]      out_data_o
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d;   // entry presented downstream
    logic [W-1:0] tail_q, tail_d;   // overflow entry caught while head stalls
    logic         w_push, w_pop;

    assign in_ready_o  = (cnt_q != CNT_FULL);
    assign out_valid_o = (cnt_q != CNT_EMPTY);
    assign out_data_o  = head_q;

    assign w_push = in_valid_i && in_ready_o;
    assign w_pop  = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            CNT_EMPTY: begin
                if (w_push) begin
                    head_d = in_data_i;
                    cnt_d  = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (w_push && w_pop) begin
                    head_d = in_data_i;
                end else if (w_push) begin
                    tail_d = in_data_i;
                    cnt_d  = CNT_FULL;
                end else if (w_pop) begin
                    cnt_d  = CNT_EMPTY;
                end
            end
            default: begin
                // Full: no push is possible, only drain the head.
                if (w_pop) begin
                    head_d = tail_q;
                    cnt_d  = CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= CNT_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/xif_result_arbiter.sv
// ============================================================================
//  Module      : xif_result_arbiter
//  Description : Merges N_COPROC X-interface result channels into the single
//                core result port. Round-robin arbitration starting at
//                rr_ptr; once a result is offered and stalled the grant is
//                locked until the downstream handshake completes.
//  Ports       : clk_i, rst_ni (sync, active low), bus (slave modport of
//                xif_result_arbiter_if)
//  Config      : XIF_RESULT_ARB_SKID_EN - insert a 2-entry skid buffer on the
//                core side (registered core outputs, 1-cycle latency, no
//                combinational core_ready_i -> res_ready_o path).
//                Undefined: combinational, zero-latency path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xif_result_arbiter
    import xif_result_arbiter_pkg::*;
#(
    parameter int N_COPROC = N_COPROC_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    xif_result_arbiter_if.slave    bus
);

    localparam int RES_WIDTH = res_width(ID_W, DATA_W);
    localparam int SRC_WIDTH = src_width(N_COPROC);

    logic [SRC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_WIDTH-1:0] grant_q, grant_d;
    logic                 lock_q, lock_d;

    logic [SRC_WIDTH-1:0] w_grant;
    logic                 w_gvalid;
    logic [RES_WIDTH-1:0] w_gres;
    logic                 w_down_ready;   // core ready, or skid has room
    logic                 w_hs;           // source-side transfer this cycle

    // ------------------------------------------------------------------
    // Grant selection. Scanning offsets from high to low lets the closest
    // requester to rr_ptr overwrite the others without a loop break.
    // ------------------------------------------------------------------
    always_comb begin : p_grant
        logic [SRC_WIDTH:0] sum;
        w_grant  = '0;
        w_gvalid = 1'b0;
        sum      = '0;
        if (lock_q) begin
            w_grant  = grant_q;
            w_gvalid = bus.res_valid_i[grant_q];
        end else begin
            for (int k = N_COPROC - 1; k >= 0; k--) begin
                sum = {1'b0, rr_ptr_q} + (SRC_WIDTH + 1)'(k);
                if (sum >= (SRC_WIDTH + 1)'(N_COPROC)) begin
                    sum = sum - (SRC_WIDTH + 1)'(N_COPROC);
                end
                if (bus.res_valid_i[sum[SRC_WIDTH-1:0]]) begin
                    w_grant  = sum[SRC_WIDTH-1:0];
                    w_gvalid = 1'b1;
                end
            end
        end
    end

    assign w_gres = bus.res_i[int'(w_grant) * RES_WIDTH +: RES_WIDTH];
    assign w_hs   = w_gvalid && w_down_ready;

    // Only the granted source sees ready; reset masks everything.
    always_comb begin : p_ready
        bus.res_ready_o = '0;
        for (int i = 0; i < N_COPROC; i++) begin
            bus.res_ready_o[i] = rst_ni && w_hs && (w_grant == SRC_WIDTH'(i));
        end
    end

`ifdef XIF_RESULT_ARB_SKID_EN
    logic [SRC_WIDTH+RES_WIDTH-1:0] w_skid_out;

    xif_result_skid #(
        .W (SRC_WIDTH + RES_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (w_gvalid),
        .in_ready_o  (w_down_ready),
        .in_data_i   ({w_grant, w_gres}),
        .out_valid_o (bus.core_valid_o),
        .out_ready_i (bus.core_ready_i),
        .out_data_o  (w_skid_out)
    );

    assign bus.core_src_o = w_skid_out[SRC_WIDTH+RES_WIDTH-1:RES_WIDTH];
    assign bus.core_res_o = w_skid_out[RES_WIDTH-1:0];
`else
    // Outputs are forced idle while reset is asserted so nothing is offered
    // to the core from state that is about to be cleared.
    assign w_down_ready     = bus.core_ready_i;
    assign bus.core_valid_o = rst_ni && w_gvalid;
    assign bus.core_res_o   = (rst_ni && w_gvalid) ? w_gres  : '0;
    assign bus.core_src_o   = (rst_ni && w_gvalid) ? w_grant : '0;
`endif

    // ------------------------------------------------------------------
    // Pointer / lock update
    // ------------------------------------------------------------------
    always_comb begin : p_next
        rr_ptr_d = rr_ptr_q;
        if (w_hs) begin
            rr_ptr_d = (w_grant == SRC_WIDTH'(N_COPROC - 1)) ? '0 : w_grant + 1'b1;
        end
        lock_d  = w_gvalid && !w_down_ready;
        grant_d = w_grant;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            lock_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            lock_q   <= lock_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xif_result_arbiter.sv
// ============================================================================
//  Module      : tb_xif_result_arbiter
//  Description : Self-checking bench for xif_result_arbiter (default build,
//                combinational path). Per-source payload queues plus a
//                behavioural arbitration model (distance from the pointer,
//                modulo N) predict every grant and payload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xif_result_arbiter;
    import xif_result_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int RW = $bits(x_result_t);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xif_result_arbiter_if #(.N_COPROC(N), .ID_W(ID_W_DEF), .DATA_W(DATA_W_DEF)) bus ();

    xif_result_arbiter #(
        .N_COPROC (N),
        .ID_W     (ID_W_DEF),
        .DATA_W   (DATA_W_DEF)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int issued    = 0;
    int delivered = 0;
    int seqno     = 0;

    x_result_t    pend_q [N][$];
    logic [N-1:0] offering = '0;
    int           m_ptr    = 0;
    int           m_held   = -1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic x_result_t mk_res(input int src);
        x_result_t r;
        r.id      = ID_W_DEF'($urandom);
        r.data    = {8'(src), 24'(seqno)};
        r.rd      = 5'($urandom);
        r.we      = 1'($urandom);
        r.exc     = 1'($urandom);
        r.exccode = 6'($urandom);
        seqno++;
        issued++;
        return r;
    endfunction

    // Expected grant: held source if stalled, else the offering source at
    // the smallest circular distance from the pointer.
    function automatic int exp_src(input logic [N-1:0] v);
        int best, bestd, d;
        if (m_held >= 0) return m_held;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic drive_sources();
        logic [N*RW-1:0] flat;
        flat = '0;
        for (int i = 0; i < N; i++) begin
            if (offering[i]) flat[i*RW +: RW] = pend_q[i][0];
        end
        bus.res_valid_i = offering;
        bus.res_i       = flat;
    endtask

    // One clock: raise requested offers (held offers persist), check DUT
    // outputs against the model at the negedge, then advance the model.
    task automatic step(input logic [N-1:0] want, input logic rdy, output int obs_src);
        int e;
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) begin
            if (!offering[i] && want[i]) begin
                if (pend_q[i].size() == 0) pend_q[i].push_back(mk_res(i));
                offering[i] = 1'b1;
            end
        end
        drive_sources();
        bus.core_ready_i = rdy;
        @(negedge clk);
        obs_src = int'(bus.core_src_o);
        e = exp_src(offering);
        check_val("core_valid", 64'(bus.core_valid_o), 64'(e >= 0));
        exp_rdy = '0;
        if (e >= 0) begin
            check_val("core_src", 64'(bus.core_src_o), 64'(e));
            check_val("core_res", 64'(bus.core_res_o), 64'(pend_q[e][0]));
            if (rdy) exp_rdy[e] = 1'b1;
        end
        check_val("res_ready", 64'(bus.res_ready_o), 64'(exp_rdy));
        if (bus.core_valid_o && rdy) delivered++;
        if (e >= 0) begin
            if (rdy) begin
                void'(pend_q[e].pop_front());
                offering[e] = 1'b0;
                m_ptr       = (e + 1) % N;
                m_held      = -1;
            end else begin
                m_held = e;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n            = 1'b0;
        bus.core_ready_i = 1'b0;
        drive_sources();
        @(negedge clk);
        check_val("rst_valid", 64'(bus.core_valid_o), 64'd0);
        check_val("rst_ready", 64'(bus.res_ready_o), 64'd0);
        check_val("rst_src", 64'(bus.core_src_o), 64'd0);
        check_val("rst_res", 64'(bus.core_res_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_held = -1;
    endtask

    initial begin
        int s;
        int first_res;
        int cycles;
        int base;
        x_result_t t1;

        bus.res_valid_i  = '0;
        bus.res_i        = '0;
        bus.core_ready_i = 1'b0;
        reset_dut();

        // Single result on channel 1.
        t1 = mk_res(1);
        t1.id   = 4'd5;
        t1.data = 32'hDEAD_BEEF;
        pend_q[1].push_back(t1);
        step(3'b010, 1'b1, s);
        check_val("t1_src", 64'(s), 64'd1);

        // Round robin from pointer 0.
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            step(3'b111, 1'b1, s);
            check_val("rr_order", 64'(s), 64'(k % 3));
        end
        step(3'b000, 1'b1, s);
        step(3'b000, 1'b1, s);

        // Backpressure with a late competing request.
        step(3'b001, 1'b0, s);
        check_val("bp_src", 64'(s), 64'd0);
        first_res = int'(bus.core_res_o[31:0]);
        for (int k = 0; k < 3; k++) begin
            step(3'b101, 1'b0, s);
            check_val("bp_src", 64'(s), 64'd0);
            check_val("bp_stable", 64'(bus.core_res_o[31:0]), 64'(first_res));
        end
        step(3'b000, 1'b1, s);
        check_val("bp_first", 64'(s), 64'd0);
        step(3'b000, 1'b1, s);
        check_val("bp_second", 64'(s), 64'd2);

        // Wrap-around: pointer at 2, channels 0 and 1 requesting.
        step(3'b010, 1'b1, s);
        step(3'b011, 1'b1, s);
        check_val("wrap_first", 64'(s), 64'd0);
        step(3'b000, 1'b1, s);
        check_val("wrap_second", 64'(s), 64'd1);

        // Reset while locked on channel 1; both sources keep offering.
        step(3'b010, 1'b0, s);
        step(3'b110, 1'b0, s);
        check_val("lock_hold", 64'(s), 64'd1);
        reset_dut();
        step(3'b000, 1'b1, s);
        check_val("rst_reoffer", 64'(s), 64'd1);
        step(3'b000, 1'b1, s);
        check_val("rst_next", 64'(s), 64'd2);

        // Random traffic: 10k results through the scoreboard.
        base   = delivered;
        cycles = 0;
        while ((delivered - base) < 10000 && cycles < 40000) begin
            step(N'($urandom), ($urandom_range(0, 9) < 7), s);
            cycles++;
        end
        check_val("rand_budget", 64'((delivered - base) >= 10000), 64'd1);

        cycles = 0;
        while (offering != '0 && cycles < 20) begin
            step(3'b000, 1'b1, s);
            cycles++;
        end
        check_val("drain_done", 64'(offering), 64'd0);
        check_val("delivered_all", 64'(delivered), 64'(issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
